// File: rtl/simd_pkg.sv
// Shared SIMD constants and the serializer state encoding, common to ALU and serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package simd_pkg;

    // Default vector geometry of the SIMD datapath.
    localparam int SIMD_LANES = 8;
    localparam int SIMD_WIDTH = 16;

    // Serializer control states: nothing held, or a vector held and draining.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } ser_state_e;

endpackage

// File: rtl/simd_lane_mux.sv
// Combinational lane selector: picks one WIDTH-bit lane out of a packed vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller owns all flow control.
module simd_lane_mux
    import simd_pkg::*;
#(
    parameter int LANES = SIMD_LANES,
    parameter int WIDTH = SIMD_WIDTH
) (
    input  logic [LANES*WIDTH-1:0]   vec_dat,
    input  logic [$clog2(LANES)-1:0] sel,
    output logic [WIDTH-1:0]         lane_dat
);

    localparam int LW = $clog2(LANES);

    // One-hot style compare per lane keeps the mux a flat AND-OR tree.
    always_comb begin
        lane_dat = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sel == LW'(i)) begin
                lane_dat = vec_dat[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/simd_result_serializer.sv
// Serializes a LANES-wide SIMD result into ascending scalar lanes; optional horizontal sum (macro SIMD_RESULT_SUM_EN).
// Latency: first lane on out_data the cycle after capture; sum_valid pulses the cycle after the last-lane transfer.
// Backpressure: out_ready=0 freezes the current lane; in_ready only in IDLE or on an accepted last lane (no bubble).
module simd_result_serializer
    import simd_pkg::*;
#(
    parameter int LANES = SIMD_LANES,
    parameter int WIDTH = SIMD_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LANES*WIDTH-1:0]           in_vec,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(LANES)-1:0]         out_lane,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH+$clog2(LANES)-1:0]   sum_data,
    output logic                             sum_valid
);

    localparam int LW = $clog2(LANES);
    localparam int SW = WIDTH + LW;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    // Control and datapath state.
    ser_state_e               state_q, state_d;
    logic [LW-1:0]            lane_q, lane_d;
    logic [LANES*WIDTH-1:0]   held_q, held_d;

    // Handshake qualifiers shared by the control and sum paths.
    logic                     is_last;
    logic                     in_xfer;
    logic                     out_xfer;
    logic [WIDTH-1:0]         lane_dat;

    // Lane selection of the held vector.
    simd_lane_mux #(
        .LANES (LANES),
        .WIDTH (WIDTH)
    ) u_lane_mux (
        .vec_dat  (held_q),
        .sel      (lane_q),
        .lane_dat (lane_dat)
    );

    // Output view and handshakes; a new vector is only taken when the held one is about to be fully drained.
    always_comb begin
        is_last   = (lane_q == LAST_LANE);
        out_valid = (state_q == ST_DRAIN);
        out_data  = lane_dat;
        out_lane  = lane_q;
        out_last  = is_last;
        in_ready  = (state_q == ST_IDLE) ||
                    ((state_q == ST_DRAIN) && is_last && out_ready);
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
    end

    // Next-state: capture wins over the last-lane return to IDLE, giving back-to-back vectors.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        held_d  = held_q;
        if (in_xfer) begin
            held_d  = in_vec;
            lane_d  = '0;
            state_d = ST_DRAIN;
        end else if (out_xfer) begin
            if (is_last) begin
                lane_d  = '0;
                state_d = ST_IDLE;
            end else begin
                lane_d  = lane_q + LW'(1);
            end
        end
    end

    // Control and held-vector registers; reset drops any partly drained vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            held_q  <= held_d;
        end
    end

`ifdef SIMD_RESULT_SUM_EN
    // Horizontal-sum path: accumulator of transferred lanes plus the reported result.
    logic [SW-1:0] acc_q, acc_d;
    logic [SW-1:0] sum_q, sum_d;
    logic          sum_vld_q, sum_vld_d;
    logic [SW-1:0] lane_ext;

    // Accumulate each accepted lane; the last lane folds straight into the result so the
    // accumulator can restart for a vector captured in the same cycle.
    always_comb begin
        lane_ext  = SW'(lane_dat);
        acc_d     = acc_q;
        sum_d     = sum_q;
        sum_vld_d = 1'b0;
        if (out_xfer) begin
            if (is_last) begin
                sum_d     = acc_q + lane_ext;
                sum_vld_d = 1'b1;
                acc_d     = '0;
            end else begin
                acc_d     = acc_q + lane_ext;
            end
        end
        if (in_xfer) begin
            acc_d = '0;
        end
    end

    // Sum registers; sum_data holds its value until the next completed vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
        end
    end

    assign sum_data  = sum_q;
    assign sum_valid = sum_vld_q;
`else
    // Sum feature compiled out: ports remain for a stable interface but are constant.
    assign sum_data  = '0;
    assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_simd_result_serializer.sv
// Self-checking bench for simd_result_serializer: table of vectors plus stall, back-to-back and reset sequences.
// Latency: expects first lane one cycle after capture, sum pulse one cycle after last lane.
// Backpressure: exercised via out_ready stalls and in_valid held during drain.
module tb_simd_result_serializer;

    localparam int L  = 8;
    localparam int W  = 16;
    localparam int LW = 3;
    localparam int SW = W + LW;

    logic              clk = 1'b0;
    logic              rst;
    logic [L*W-1:0]    in_vec;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      out_data;
    logic [LW-1:0]     out_lane;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     sum_data;
    logic              sum_valid;

    simd_result_serializer #(.LANES(L), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_data  (sum_data),
        .sum_valid (sum_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Scoreboard of expected lanes, filled from accepted input vectors.
    typedef struct packed {
        logic [W-1:0]  data;
        logic [LW-1:0] lane;
        logic          last;
    } sb_ent_t;

    sb_ent_t        sb[$];
    sb_ent_t        ent;
    bit             mon_en = 1'b0;
    bit             m_empty;
    bit             m_inrdy;
    bit             sum_due = 1'b0;
    logic [SW-1:0]  sum_due_val;
    logic [SW-1:0]  sb_acc = '0;
    int             run_len = 0;
    int             run_gaps = 0;
    int             run_prev = 0;

    // Monitor: every cycle compares flags, current lane and sum pulse against the model.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            sb_acc  = '0;
            sum_due = 1'b0;
        end else if (mon_en) begin
            m_empty = (sb.size() == 0);
            m_inrdy = m_empty || (sb[0].last && out_ready);
            chk("flags_valid_ready", {62'd0, out_valid, in_ready}, {62'd0, !m_empty, m_inrdy});
            if (!m_empty)
                chk("lane_out", {44'd0, out_data, out_lane, out_last},
                    {44'd0, sb[0].data, sb[0].lane, sb[0].last});
`ifdef SIMD_RESULT_SUM_EN
            if (sum_due || sum_valid)
                chk("sum_pulse", {44'd0, sum_valid, sum_data}, {44'd0, sum_due, sum_due_val});
`else
            if (sum_due)
                chk("sum_tied_off", {44'd0, sum_valid, sum_data}, 64'd0);
`endif
            sum_due = 1'b0;
            if (!m_empty && out_ready) begin
                ent = sb.pop_front();
                sb_acc = sb_acc + SW'(ent.data);
                if (run_len > 0 && cyc_n != run_prev + 1) run_gaps++;
                run_prev = cyc_n;
                run_len++;
                if (ent.last) begin
                    sum_due     = 1'b1;
                    sum_due_val = sb_acc;
                    sb_acc      = '0;
                end
            end
            if (in_valid && m_inrdy) begin
                for (int i = 0; i < L; i++) begin
                    ent.data = in_vec[i*W +: W];
                    ent.lane = LW'(i);
                    ent.last = (i == L - 1);
                    sb.push_back(ent);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until accepted; reports how many cycles it was offered.
    task automatic wait_accept(output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            waited++;
            step();
        end
        if (!done) fail_timeout("accept");
    endtask

    task automatic send_vec(input logic [L*W-1:0] v);
        int w;
        in_vec   = v;
        in_valid = 1'b1;
        wait_accept(w);
        in_valid = 1'b0;
    endtask

    task automatic drain_wait();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            done = !out_valid;
            if (!done) step();
        end
        if (!done) fail_timeout("drain");
    endtask

    typedef struct {
        logic [L*W-1:0] vec;
        logic [SW-1:0]  exp_sum;
    } vec_rec_t;

    vec_rec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [L*W-1:0] va;
        logic [L*W-1:0] vb;
        logic [SW-1:0]  exp_s;
        int             w;

        // Vector table: lanes 1..8, all ones, ramp of 0x1000 steps, all zero.
        for (int i = 0; i < L; i++) begin
            tbl[0].vec[i*W +: W] = W'(i + 1);
            tbl[1].vec[i*W +: W] = 16'hFFFF;
            tbl[2].vec[i*W +: W] = W'(i * 16'h1000);
            tbl[3].vec[i*W +: W] = 16'h0000;
        end
        tbl[0].exp_sum = 19'd36;
        tbl[1].exp_sum = 19'h7FFF8;
        tbl[2].exp_sum = 19'h1C000;
        tbl[3].exp_sum = 19'd0;

        rst       = 1'b1;
        in_vec    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_state", {41'd0, out_valid, in_ready, sum_valid, sum_data, out_lane},
            {41'd0, 1'b0, 1'b1, 1'b0, 19'd0, 3'd0});
        step();

        // Table-driven single vectors with a free-running consumer.
        for (int t = 0; t < 4; t++) begin
            run_len  = 0;
            run_gaps = 0;
            send_vec(tbl[t].vec);
            drain_wait();
            step();
            @(negedge clk);
`ifdef SIMD_RESULT_SUM_EN
            exp_s = tbl[t].exp_sum;
`else
            exp_s = '0;
`endif
            chk("tbl_sum", {45'd0, sum_data}, {45'd0, exp_s});
            chk("tbl_run_len_gaps", {run_len, run_gaps}, {32'd8, 32'd0});
            step();
        end

        // Stall at lane 2 for three cycles while a second vector waits.
        for (int i = 0; i < L; i++) begin
            va[i*W +: W] = W'(16'h0010 + i);
            vb[i*W +: W] = W'(16'h0A00 + i);
        end
        run_len  = 0;
        run_gaps = 0;
        send_vec(va);
        step();
        step();
        out_ready = 1'b0;
        in_vec    = vb;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_hold", {59'd0, out_valid, out_lane, in_ready}, {59'd0, 1'b1, 3'd2, 1'b0});
            step();
        end
        out_ready = 1'b1;
        wait_accept(w);
        in_valid = 1'b0;
        drain_wait();
        chk("stall_run_len_gaps", {run_len, run_gaps}, {32'd16, 32'd1});
        step();

        // Two vectors offered back-to-back: sixteen gapless transfers.
        run_len  = 0;
        run_gaps = 0;
        in_vec   = vb;
        in_valid = 1'b1;
        wait_accept(w);
        in_vec = tbl[0].vec;
        wait_accept(w);
        chk("b2b_accept_on_lane7", w, 64'd8);
        in_valid = 1'b0;
        drain_wait();
        chk("b2b_run_len_gaps", {run_len, run_gaps}, {32'd16, 32'd0});
        step();

        // Reset at lane 4: the partial vector is discarded, the next one sums from zero.
        send_vec(va);
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_at_lane4", {60'd0, out_valid, out_lane}, {60'd0, 1'b1, 3'd4});
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst", {61'd0, out_valid, in_ready, sum_valid}, {61'd0, 1'b0, 1'b1, 1'b0});
        step();
        run_len  = 0;
        run_gaps = 0;
        send_vec(tbl[0].vec);
        drain_wait();
        step();
        @(negedge clk);
`ifdef SIMD_RESULT_SUM_EN
        exp_s = 19'd36;
`else
        exp_s = '0;
`endif
        chk("post_rst_sum", {45'd0, sum_data}, {45'd0, exp_s});
        chk("post_rst_run", {run_len, run_gaps}, {32'd8, 32'd0});
        step();

        chk("scoreboard_drained", sb.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
